pwm_multi_ch: RTL and testbench
===============================

# pwm_multi_ch

Multi-channel PWM generator for the ammeter-clock needle drivers. It is the parametrised successor of the single-channel PWM driver: CH channels share one period counter, and each channel has its own duty. Period and duty are written into shadow registers and take effect only at a period boundary, so needles never see a glitched cycle. An optional slew limiter walks each duty toward its target to smooth needle motion.

## Interface
- `N`, 16, width of the period counter, period and each duty value
- `CH`, 3, number of PWM channels (hour/minute/second needles)
- `SLEW_STEP`, 1, maximum duty change per period boundary (used only with slew enabled)

- `clk`  in  1  system clock; all logic on the rising edge
- `Rst`  in  1  synchronous, active-high reset
- `period`  in  N  PWM period in clk cycles; sampled on `load`
- `duty`  in  CH*N  per-channel duty; channel i is bits [i*N+N-1 : i*N]; sampled on `load`
- `load`  in  1  one-cycle strobe that captures `period` and `duty` into the shadow registers
- `en`  in  CH  per-channel enable, live (not shadowed)
- `PWM`  out  CH  registered PWM outputs
- `period_end`  out  1  one-cycle pulse, registered, marking each period boundary
- `pending`  out  1  high while the shadow values are not yet fully applied

## Operation
- Register sets:
  - shadow: `period_s`, `duty_s[i]`
  - active: `period_a`, `duty_a[i]`
  - counter: `cnt`, N bits
- `load`: shadow takes the inputs and `pending` is set. A new `load` while `pending` is high overwrites the shadow registers.
- Counter runs 0 .. `period_a`-1, then returns to 0. Boundary = (`cnt` == `period_a`-1) or (`period_a` == 0).
- `period_a` == 0: `cnt` is held at 0, every cycle is a boundary, and all `PWM` outputs are 0.
- At a boundary:
  - `period_a` takes `period_s`.
  - `duty_a` takes `duty_s` (or slews toward it, see Configuration).
  - `pending` clears once active equals shadow.
- `load` in the same cycle as a boundary: the new input values go directly to both the shadow and active registers, and `pending` stays 0 (slew-disabled build).
- Channel output: `PWM[i]` takes `en[i]` AND (`cnt` < `duty_a[i]`).
  - `duty_a` = 0 gives a constant 0.
  - `duty_a` ≥ `period_a` (nonzero period) gives a constant 1.
- All comparisons are unsigned and N bits wide. `cnt` never exceeds `period_a`-1, so no wrap beyond the period is possible.
- Reset: `cnt`, all shadow and active registers, `PWM`, `period_end` and `pending` are all 0.

## Timing
- `PWM` and `period_end` lag `cnt` by one cycle (registered compare).
- Load to effect:
  - Shadow is valid the cycle after `load`.
  - Active values change at the next boundary.
  - `PWM` reflects the new values one cycle after that boundary.
- After reset, `period_a` = 0, so a first `load` is applied at the next cycle's boundary, and `PWM` can start two cycles after `load`.
- `period_end` pulses the cycle after `cnt` == `period_a`-1. With `period_a` = 0 it is held high every cycle.
- `en` deassertion forces `PWM[i]` to 0 one cycle later, mid-period, with no boundary wait.
- `Rst` asserted mid-period: all outputs are 0 the following cycle, and the counter restarts from 0 after release.

## Configuration
- `PWM_SLEW_EN` defined:
  - At each boundary, each `duty_a[i]` moves toward `duty_s[i]` by min(`SLEW_STEP`, |difference|).
  - `period_a` is still applied in one step.
  - `pending` stays high until every channel reaches its target.
  - A `load` coincident with a boundary only writes the shadow registers; slewing starts from the current active duty.
- `PWM_SLEW_EN` undefined: duties jump directly to the shadow value at the boundary, and `SLEW_STEP` is ignored.

## Test plan
- Reset, then `load` `period`=10, duty ch0=3, ch1=0, ch2=10, `en`=3'b111:
  - ch0 is high exactly 3 of every 10 cycles.
  - ch1 is constant 0 and ch2 is constant 1.
  - `period_end` pulses every 10 cycles.
- Mid-period `load` of ch0=7 at `cnt`=4: the current period keeps duty 3, the next period shows 7 high cycles, and `pending` clears at the boundary.
- `load` coincident with `cnt`=9 (boundary), no slew: the new duty is visible in the very next period and `pending` stays 0.
- `en[1]` dropped mid-high with ch1 duty=8: `PWM[1]` is 0 one cycle later, while other channels are unaffected.
- `load` with `period`=0: all `PWM` outputs are 0 and `period_end` is held at 1. A subsequent `load` of `period`=5 starts PWM within two cycles.
- With `PWM_SLEW_EN`, `SLEW_STEP`=2, ch0 going from 3 to 9:
  - Successive periods show 5, 7, 9 high cycles.
  - `pending` falls after the third boundary.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM with a shared period counter and boundary-synchronised shadow registers.
// Define PWM_SLEW_EN to have duties walk toward their targets by at most SLEW_STEP per period.
module pwm_multi_ch #(
    parameter int N         = 16,
    parameter int CH        = 3,
    parameter int SLEW_STEP = 1
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic [N-1:0]    period,
    input  logic [CH*N-1:0] duty,
    input  logic            load,
    input  logic [CH-1:0]   en,
    output logic [CH-1:0]   PWM,
    output logic            period_end,
    output logic            pending
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0]          cnt_q, cnt_d;
    logic [N-1:0]          period_s_q, period_s_d;
    logic [N-1:0]          period_a_q, period_a_d;
    logic [CH-1:0][N-1:0]  duty_s_q, duty_s_d;
    logic [CH-1:0][N-1:0]  duty_a_q, duty_a_d;
    logic [CH-1:0][N-1:0]  duty_in, duty_nx;
    logic [CH-1:0]         pwm_q, pwm_d;
    logic                  period_end_q;
    logic                  pend_q, pend_d;
    logic                  boundary, mismatch;

    assign duty_in  = duty;
    assign boundary = (period_a_q == '0) || (cnt_q == period_a_q - ONE);

`ifdef PWM_SLEW_EN
    localparam logic [N-1:0] STEP = N'(SLEW_STEP);

    function automatic logic [N-1:0] slew_to(input logic [N-1:0] a, input logic [N-1:0] s);
        logic [N-1:0] diff;
        if (s >= a) begin
            diff = s - a;
            return a + ((diff > STEP) ? STEP : diff);
        end
        diff = a - s;
        return a - ((diff > STEP) ? STEP : diff);
    endfunction

    always_comb begin
        duty_nx = duty_a_q;
        for (int i = 0; i < CH; i++) duty_nx[i] = slew_to(duty_a_q[i], duty_s_q[i]);
    end
`else
    assign duty_nx = duty_s_q;
`endif

    always_comb begin
        cnt_d      = boundary ? '0 : cnt_q + ONE;
        period_s_d = period_s_q;
        duty_s_d   = duty_s_q;
        period_a_d = period_a_q;
        duty_a_d   = duty_a_q;
        pend_d     = pend_q;
        if (load) begin
            period_s_d = period;
            duty_s_d   = duty_in;
        end
        if (boundary) begin
            period_a_d = period_s_q;
            duty_a_d   = duty_nx;
`ifndef PWM_SLEW_EN
            // A load landing on a boundary bypasses the shadow stage entirely.
            if (load) begin
                period_a_d = period;
                duty_a_d   = duty_in;
            end
`endif
        end
        mismatch = (period_a_d != period_s_d) || (duty_a_d != duty_s_d);
        if (boundary)  pend_d = mismatch;
        else if (load) pend_d = 1'b1;
    end

    // Zero period forces the outputs low even though cnt < duty may hold.
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CH; i++)
            pwm_d[i] = en[i] && (period_a_q != '0) && (cnt_q < duty_a_q[i]);
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            cnt_q        <= '0;
            period_s_q   <= '0;
            period_a_q   <= '0;
            duty_s_q     <= '0;
            duty_a_q     <= '0;
            pwm_q        <= '0;
            period_end_q <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            period_s_q   <= period_s_d;
            period_a_q   <= period_a_d;
            duty_s_q     <= duty_s_d;
            duty_a_q     <= duty_a_d;
            pwm_q        <= pwm_d;
            period_end_q <= boundary;
            pend_q       <= pend_d;
        end
    end

    assign PWM        = pwm_q;
    assign period_end = period_end_q;
    assign pending    = pend_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Scoreboard bench for pwm_multi_ch: stimulus queues time-tagged expectations, a negedge monitor checks them.
module tb_pwm_multi_ch;

`ifdef PWM_SLEW_EN
    localparam int SS = 2;
`else
    localparam int SS = 1;
`endif

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic [15:0] period = '0;
    logic [47:0] duty = '0;
    logic        load = 1'b0;
    logic [2:0]  en = '0;
    logic [2:0]  PWM;
    logic        period_end;
    logic        pending;

    pwm_multi_ch #(.N(16), .CH(3), .SLEW_STEP(SS)) dut (
        .clk(clk), .Rst(Rst), .period(period), .duty(duty), .load(load),
        .en(en), .PWM(PWM), .period_end(period_end), .pending(pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bits: [4:2] PWM[2:0], [1] period_end, [0] pending.
    typedef struct {
        int         t;
        logic [4:0] m;
        logic [4:0] v;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   ph0 = 0;

    always @(negedge clk) begin
        logic [4:0] obs;
        obs = {PWM, period_end, pending};
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].t == cyc) begin
                checks++;
                if ((obs & sb[i].m) !== (sb[i].v & sb[i].m)) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%b expected=%b mask=%b", sb[i].nm, cyc, obs, sb[i].v, sb[i].m);
                end
                sb.delete(i);
            end else if (sb[i].t < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s missed cyc=%0d got=none expected=%b", sb[i].nm, sb[i].t, sb[i].v);
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int d, input logic [4:0] m, input logic [4:0] v, input string nm);
        exp_t e;
        e.t  = cyc + d;
        e.m  = m;
        e.v  = v;
        e.nm = nm;
        sb.push_back(e);
    endtask

    // Output pattern for a steady period: entry j reflects counter value j % per.
    task automatic push_pwm(input int d0, input int per, input int n,
                            input int du0, input int du1, input int du2, input string nm);
        for (int j = 0; j < n; j++)
            push(d0 + j, 5'b11110,
                 {((j % per) < du2), ((j % per) < du1), ((j % per) < du0), ((j % per) == per - 1), 1'b0}, nm);
    endtask

    task automatic do_load(input int per, input int d0, input int d1, input int d2);
        period = 16'(per);
        duty   = {16'(d2), 16'(d1), 16'(d0)};
        load   = 1'b1;
        step(1);
        load   = 1'b0;
    endtask

    task automatic wait_cnt(input int k, input int per);
        int g;
        g = 0;
        while ((((cyc - ph0) % per) != k) && (g < 100)) begin
            step(1);
            g++;
        end
    endtask

    initial begin
        step(3);
        push(0, 5'b11111, 5'b00000, "reset_state");
        step(1);
        Rst = 1'b0;
        en  = 3'b111;
        push(0, 5'b11111, 5'b00000, "reset_release");
        push(1, 5'b11111, 5'b00010, "zero_period_idle");
        step(1);

`ifndef PWM_SLEW_EN
        // Basic pattern: period 10, duties 3 / 0 / 10.
        do_load(10, 3, 0, 10);
        ph0 = cyc;
        push(0, 5'b11111, 5'b00010, "first_load_edge");
        push_pwm(1, 10, 30, 3, 0, 10, "basic_pattern");
        for (int j = 1; j < 4; j++) push(j, 5'b00001, 5'b00000, "basic_pending");
        step(30);

        // Mid-period load keeps the running period on the old duty.
        wait_cnt(4, 10);
        do_load(10, 7, 0, 10);
        for (int j = 0; j < 5; j++) push(j, 5'b11101, 5'b10001, "midload_old_period");
        push(5, 5'b11111, 5'b10010, "midload_boundary");
        push_pwm(6, 10, 10, 7, 0, 10, "midload_new_duty");
        step(16);

        // Load on the boundary cycle is applied immediately.
        wait_cnt(9, 10);
        do_load(10, 5, 8, 10);
        push(0, 5'b11111, 5'b10010, "bndload_edge");
        push_pwm(1, 10, 10, 5, 8, 10, "bndload_pattern");
        for (int j = 0; j < 3; j++) push(j, 5'b00001, 5'b00000, "bndload_pending");
        step(12);

        // Channel enable drop takes effect one cycle later, mid-period.
        wait_cnt(3, 10);
        en = 3'b101;
        push(1, 5'b11100, 5'b10100, "en_drop_1");
        push(2, 5'b11100, 5'b10100, "en_drop_2");
        push(3, 5'b11100, 5'b10000, "en_drop_3");
        step(4);
        en = 3'b111;

        // Zero period: outputs low, period_end held high.
        wait_cnt(4, 10);
        do_load(0, 5, 8, 10);
        for (int j = 0; j < 5; j++) push(j, 5'b00001, 5'b00001, "p0_pending");
        push(5, 5'b11111, 5'b10010, "p0_boundary");
        for (int j = 6; j < 11; j++) push(j, 5'b11111, 5'b00010, "p0_idle");
        step(12);

        // Restart from zero period with period 5.
        do_load(5, 2, 5, 0);
        ph0 = cyc;
        push(0, 5'b11111, 5'b00010, "p5_edge");
        push_pwm(1, 5, 15, 2, 5, 0, "p5_pattern");
        for (int j = 0; j < 3; j++) push(j, 5'b00001, 5'b00000, "p5_pending");
        step(16);

        // Reset asserted mid-period.
        wait_cnt(1, 5);
        Rst = 1'b1;
        step(1);
        push(0, 5'b11111, 5'b00000, "midreset");
        Rst = 1'b0;
        push(1, 5'b11111, 5'b00010, "midreset_release");
        step(2);
`else
        begin
            int g;
            do_load(10, 3, 0, 10);
            g = 0;
            while ((pending || g < 2) && g < 300) begin
                step(1);
                g++;
            end
            g = 0;
            while (!period_end && g < 30) begin
                step(1);
                g++;
            end
            if (g >= 30 || pending) begin
                checks++;
                failures++;
                $display("FAIL slew_settle got pending=%b period_end=%b expected=0/1", pending, period_end);
            end
            ph0 = cyc;
            wait_cnt(4, 10);
            do_load(10, 9, 0, 10);
            push(0, 5'b00001, 5'b00001, "slew_pending_0");
            push(5, 5'b00001, 5'b00001, "slew_pending_5");
            push(15, 5'b00001, 5'b00001, "slew_pending_15");
            push(24, 5'b00001, 5'b00001, "slew_pending_24");
            push(25, 5'b00001, 5'b00000, "slew_pending_done");
            push(26, 5'b00001, 5'b00000, "slew_pending_low");
            push_pwm(6, 10, 10, 5, 0, 10, "slew_step5");
            push_pwm(16, 10, 10, 7, 0, 10, "slew_step7");
            push_pwm(26, 10, 10, 9, 0, 10, "slew_step9");
            step(40);
        end
`endif

        begin
            int g;
            g = 0;
            while (sb.size() != 0 && g < 200) begin
                step(1);
                g++;
            end
            if (sb.size() != 0) begin
                checks++;
                failures++;
                $display("FAIL drain got=%0d pending expectations expected=0", sb.size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
